// File: rtl/req_queue_subo_pkg.sv
`default_nettype none
// ============================================================================
// Module : req_queue_subo_pkg
// Brief  : Shared widths, default depth and the request record used by the
//          request queue and its storage sub-module.
// Rev    : 1.0 - initial release
// ============================================================================
package req_queue_subo_pkg;

  localparam int c_ID_W              = 4;
  localparam int c_ADDR_W            = 32;
  localparam int c_DEFAULT_DEPTH     = 4;
  localparam int c_DEFAULT_DEPTH_LOG2 = 2;

  typedef struct packed {
    logic [c_ID_W-1:0]   id;
    logic [c_ADDR_W-1:0] addr;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/req_queue_mem.sv
`default_nettype none
// ============================================================================
// Module : req_queue_mem
// Brief  : Storage array plus read/write pointers for the request queue.
//          A slot is reserved one cycle before its data is written; the
//          reserved index is remembered so the late write lands correctly.
// Ports  : clk        - clock
//          rst_n      - synchronous active-low reset (pointers only)
//          i_reserve  - reserve the slot at the write pointer
//          i_write    - write i_wr_data into the last reserved slot
//          i_wr_data  - request record being written
//          i_read     - advance the read pointer (entry consumed)
//          o_rd_data  - oldest entry, bypassed from i_wr_data when that
//                       entry is being written this very cycle
// Rev    : 1.0 - initial release
// ============================================================================
module req_queue_mem
  import req_queue_subo_pkg::*;
#(
  parameter int DEPTH      = c_DEFAULT_DEPTH,
  parameter int DEPTH_LOG2 = c_DEFAULT_DEPTH_LOG2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_reserve,
  input  logic i_write,
  input  req_t i_wr_data,
  input  logic i_read,
  output req_t o_rd_data
);

  req_t                  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2-1:0] r_wslot;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wslot <= '0;
    end else begin
      if (i_reserve) begin
        r_wptr  <= r_wptr + DEPTH_LOG2'(1);
        r_wslot <= r_wptr;
      end
      if (i_read) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_write) begin
      r_mem[r_wslot] <= i_wr_data;
    end
  end

  // The pending slot can only be the oldest one when everything older has
  // already left, so matching indices means "read what is being written".
  always_comb begin
    o_rd_data = r_mem[r_rptr];
    if (i_write && (r_rptr == r_wslot)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_queue_subo.sv
`default_nettype none
// ============================================================================
// Module : req_queue_subo
// Brief  : In-order request queue. A push reserves a slot in the strobe
//          cycle and writes the ID/address the cycle after. The head entry is
//          presented through a single output register with valid/ready.
// Ports  : clk          - clock
//          rst_n        - synchronous active-low reset
//          reqc_s_valid - push strobe
//          reqc_s_id    - request ID, valid one cycle after the strobe
//          reqc_s_addr  - request address, valid one cycle after the strobe
//          qfull_1      - almost-full (reserved slots >= DEPTH-1)
//          rq_valid     - head request presented
//          rq_ready     - memory-side acceptance
//          rq_id        - head request ID
//          rq_addr      - head request address
// Rev    : 1.0 - initial release
// ============================================================================
module req_queue_subo
  import req_queue_subo_pkg::*;
#(
  parameter int DEPTH      = c_DEFAULT_DEPTH,
  parameter int DEPTH_LOG2 = c_DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reqc_s_valid,
  input  logic [c_ID_W-1:0]   reqc_s_id,
  input  logic [c_ADDR_W-1:0] reqc_s_addr,
  output logic                qfull_1,
  output logic                rq_valid,
  input  logic                rq_ready,
  output logic [c_ID_W-1:0]   rq_id,
  output logic [c_ADDR_W-1:0] rq_addr
);

  localparam logic [DEPTH_LOG2:0] c_FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  logic [DEPTH_LOG2:0] r_cnt;
  logic                r_pend;
  logic                r_rq_valid;
  req_t                r_rq;

  logic w_qfull;
  logic w_push;
  logic w_load_slot;
  logic w_load;
  logic w_write;
  req_t w_wr_data;
  req_t w_rd_data;

  assign w_qfull     = (r_cnt >= c_FULL_LVL);
  assign w_push      = reqc_s_valid & ~w_qfull;
  // Output register may take a new entry when it is empty or being popped.
  assign w_load_slot = ~r_rq_valid | rq_ready;
  // Any reserved slot is loadable: a reservation from the previous cycle is
  // being written at this edge and is bypassed by the storage.
  assign w_load      = w_load_slot & (r_cnt != '0);
  // A reset in the data cycle discards the pending write.
  assign w_write     = r_pend & rst_n;
  assign w_wr_data   = '{id: reqc_s_id, addr: reqc_s_addr};

  req_queue_mem #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_reserve (w_push),
    .i_write   (w_write),
    .i_wr_data (w_wr_data),
    .i_read    (w_load),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_rq_valid <= 1'b0;
      r_rq       <= '0;
    end else begin
      r_pend <= w_push;
      if (w_push && !w_load) begin
        r_cnt <= r_cnt + (DEPTH_LOG2 + 1)'(1);
      end else if (!w_push && w_load) begin
        r_cnt <= r_cnt - (DEPTH_LOG2 + 1)'(1);
      end
      if (w_load_slot) begin
        r_rq_valid <= w_load;
        if (w_load) begin
          r_rq <= w_rd_data;
        end
      end
    end
  end

  assign qfull_1  = w_qfull;
  assign rq_valid = r_rq_valid;
  assign rq_id    = r_rq.id;
  assign rq_addr  = r_rq.addr;

endmodule
`default_nettype wire

// File: tb/tb_req_queue_subo.sv
`default_nettype none
// ============================================================================
// Module : tb_req_queue_subo
// Brief  : Self-checking bench for req_queue_subo: directed scenarios with
//          literal expectations plus randomized traffic against a
//          queue-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_req_queue_subo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqc_s_valid = 1'b0;
  logic [3:0]  reqc_s_id = '0;
  logic [31:0] reqc_s_addr = '0;
  logic        qfull_1;
  logic        rq_valid;
  logic        rq_ready = 1'b0;
  logic [3:0]  rq_id;
  logic [31:0] rq_addr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: entries whose data has arrived, plus a flag for a
  // reservation whose data arrives next cycle, plus the output register.
  logic [35:0] store [$];
  logic        m_pend  = 1'b0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_id    = '0;
  logic [31:0] m_addr  = '0;

  always #5 clk = ~clk;

  req_queue_subo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reqc_s_valid (reqc_s_valid),
    .reqc_s_id    (reqc_s_id),
    .reqc_s_addr  (reqc_s_addr),
    .qfull_1      (qfull_1),
    .rq_valid     (rq_valid),
    .rq_ready     (rq_ready),
    .rq_id        (rq_id),
    .rq_addr      (rq_addr)
  );

  function automatic logic m_full();
    return (store.size() + int'(m_pend)) >= DEPTH - 1;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance model across the edge, then
  // compare every DUT output against the model away from the edge.
  task automatic step(input logic v, input logic rdy, input logic [3:0] id,
                      input logic [31:0] addr, input logic rn);
    logic acc;
    reqc_s_valid = v;
    rq_ready     = rdy;
    reqc_s_id    = id;
    reqc_s_addr  = addr;
    rst_n        = rn;
    if (!rn) begin
      store.delete();
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_id    = '0;
      m_addr  = '0;
    end else begin
      acc = v && !m_full();
      if (m_pend) store.push_back({id, addr});
      if (!m_valid || rdy) begin
        if (store.size() > 0) begin
          {m_id, m_addr} = store.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = acc;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rq_valid", {35'd0, rq_valid}, {35'd0, m_valid});
    chk("qfull_1", {35'd0, qfull_1}, {35'd0, m_full()});
    chk("rq_id", {32'd0, rq_id}, {32'd0, m_id});
    chk("rq_addr", {4'd0, rq_addr}, {4'd0, m_addr});
  endtask

  initial begin
    int nvalid;
    logic sawfull;
    logic [3:0] exp_next;

    @(negedge clk);
    // Reset state
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("reset_valid", {35'd0, rq_valid}, 36'd0);
    chk("reset_full", {35'd0, qfull_1}, 36'd0);
    chk("reset_addr", {4'd0, rq_addr}, 36'd0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    chk("release_valid", {35'd0, rq_valid}, 36'd0);

    // Single push, ready high: visible exactly in cycle t+2, for one cycle
    step(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1);
    chk("single_t1_valid", {35'd0, rq_valid}, 36'd0);
    step(1'b0, 1'b1, 4'h3, 32'h0000_1000, 1'b1);
    chk("single_t2_valid", {35'd0, rq_valid}, 36'd1);
    chk("single_t2_id", {32'd0, rq_id}, 36'd3);
    chk("single_t2_addr", {4'd0, rq_addr}, 36'h0000_1000);
    step(1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
    chk("single_t3_valid", {35'd0, rq_valid}, 36'd0);
    chk("single_t3_full", {35'd0, qfull_1}, 36'd0);

    // Fill with ready low: first entry sits in the output register, the
    // next three occupy DEPTH-1 slots and raise qfull_1.
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 4'h1, 32'h100, 1'b1);
    step(1'b1, 1'b0, 4'h2, 32'h200, 1'b1);
    chk("fill_3_full", {35'd0, qfull_1}, 36'd0);
    step(1'b1, 1'b0, 4'h3, 32'h300, 1'b1);
    chk("fill_4_full", {35'd0, qfull_1}, 36'd1);
    step(1'b0, 1'b0, 4'h4, 32'h400, 1'b1);
    // Ignored push attempt while full
    step(1'b1, 1'b0, 4'h9, 32'h900, 1'b1);
    step(1'b0, 1'b0, 4'hA, 32'hA00, 1'b1);
    chk("ignored_full", {35'd0, qfull_1}, 36'd1);
    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
      chk("bp_hold_id", {32'd0, rq_id}, 36'd1);
      chk("bp_hold_addr", {4'd0, rq_addr}, 36'h100);
    end
    // Drain in push order; the ignored push never shows up
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
      chk("drain_id", {32'd0, rq_id}, 36'(i));
      chk("drain_valid", {35'd0, rq_valid}, 36'd1);
    end
    step(1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
    chk("drain_empty", {35'd0, rq_valid}, 36'd0);

    // Continuous pushes with ready high: ten pops on consecutive cycles
    nvalid   = 0;
    sawfull  = 1'b0;
    exp_next = 4'd0;
    for (int i = 0; i <= 13; i++) begin
      step(i < 10, 1'b1, 4'(i - 1), 32'(i * 16 + 7), 1'b1);
      if (qfull_1) sawfull = 1'b1;
      if (rq_valid) begin
        nvalid++;
        chk("stream_order", {32'd0, rq_id}, {32'd0, exp_next});
        exp_next = exp_next + 4'd1;
      end
      if (i >= 1 && i <= 10) chk("stream_back2back", {35'd0, rq_valid}, 36'd1);
    end
    chk("stream_count", 36'(nvalid), 36'd10);
    chk("stream_nofull", {35'd0, sawfull}, 36'd0);

    // Reset in the data cycle discards the pending write
    step(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 4'h5, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
    chk("rst_discard_valid", {35'd0, rq_valid}, 36'd0);
    chk("rst_discard_addr", {4'd0, rq_addr}, 36'd0);
    step(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 4'h6, 32'h1234_5678, 1'b1);
    chk("post_rst_id", {32'd0, rq_id}, 36'd6);
    chk("post_rst_addr", {4'd0, rq_addr}, 36'h1234_5678);

    // Randomized traffic, including pushes against qfull_1 and rare resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom), 32'($urandom), 1'($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
